// File: rtl/itimer_pkg.sv
// Shared definitions for the N-channel interval timer.
// Mode encodings and the prescale-shift lookup.
package itimer_pkg;

    localparam logic [1:0] C_TIM_0001T = 2'b00;
    localparam logic [1:0] C_TIM_0008T = 2'b01;
    localparam logic [1:0] C_TIM_0064T = 2'b10;
    localparam logic [1:0] C_TIM_1024T = 2'b11;

    function automatic int presc_shift(
        input logic [1:0] m,
        input int         s1,
        input int         s2,
        input int         s3
    );
        case (m)
            C_TIM_0008T: return s1;
            C_TIM_0064T: return s2;
            C_TIM_1024T: return s3;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/itimer_ch.sv
// One interval-timer channel: prescaler, down-counter,
// sticky underflow state, read-to-clear flag and IRQ enable.
module itimer_ch
    import itimer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH1   = 3,
    parameter int SH2   = 6,
    parameter int SH3   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [1:0]       mode_in,
    input  logic             irq_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             flag,
    output logic             irq
);

    logic [SH3-1:0]   div;
    logic [WIDTH-1:0] cnt;
    logic             uf;
    logic [1:0]       mode;
    logic             en;
    logic [SH3-1:0]   mask;
    logic             tick;
    logic             under;

    // mask covers the low SHk divider bits of the current mode
    always_comb begin
        mask  = SH3'((32'd1 << presc_shift(mode, SH1, SH2, SH3)) - 32'd1);
        tick  = (mode == C_TIM_0001T) || ((div & mask) == mask);
        under = !uf && tick && (cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            cnt  <= '0;
            uf   <= 1'b0;
            mode <= C_TIM_0001T;
            en   <= 1'b0;
            flag <= 1'b0;
        end else if (we) begin
            div  <= '0;
            cnt  <= din;
            uf   <= 1'b0;
            mode <= mode_in;
            en   <= irq_en;
            flag <= 1'b0;
        end else begin
            div <= div + SH3'(1);
            if (uf || tick)
                cnt <= cnt - WIDTH'(1);
            if (under)
                uf <= 1'b1;
            if (under)
                flag <= 1'b1;
            else if (re)
                flag <= 1'b0;
        end
    end

    assign dout = uf ? (~cnt + WIDTH'(1)) : cnt;
    assign irq  = flag & en;

endmodule

// File: rtl/itimer_nch.sv
// N-channel programmable interval timer: select decode,
// count read-back mux and wired-OR interrupt.
module itimer_nch
    import itimer_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 8,
    parameter int SH1   = 3,
    parameter int SH2   = 6,
    parameter int SH3   = 10,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             WE,
    input  logic [SEL_W-1:0] SEL,
    input  logic [1:0]       MODE,
    input  logic             IRQ_EN,
    input  logic [WIDTH-1:0] IN,
    input  logic             RE,
    output logic [WIDTH-1:0] OUT,
    output logic [NCH-1:0]   FLAG,
    output logic             IRQ
);

    logic [NCH-1:0]   we_ch;
    logic [NCH-1:0]   re_ch;
    logic [NCH-1:0]   irq_ch;
    logic [WIDTH-1:0] cnt_ch [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign we_ch[i] = WE && (SEL == SEL_W'(i));
        assign re_ch[i] = RE && (SEL == SEL_W'(i));

        itimer_ch #(
            .WIDTH(WIDTH),
            .SH1  (SH1),
            .SH2  (SH2),
            .SH3  (SH3)
        ) u_ch (
            .clk    (CLK),
            .rst    (RES),
            .we     (we_ch[i]),
            .re     (re_ch[i]),
            .mode_in(MODE),
            .irq_en (IRQ_EN),
            .din    (IN),
            .dout   (cnt_ch[i]),
            .flag   (FLAG[i]),
            .irq    (irq_ch[i])
        );
    end

    // out-of-range selects read as zero
    always_comb begin
        OUT = '0;
        for (int i = 0; i < NCH; i++)
            if (SEL == SEL_W'(i))
                OUT = cnt_ch[i];
    end

    assign IRQ = |irq_ch;

endmodule

// File: tb/tb_itimer_nch.sv
// Directed bench for itimer_nch (three channels so an
// out-of-range select exists).
module tb_itimer_nch;

    localparam int NCH   = 3;
    localparam int WIDTH = 8;
    localparam int SW    = 2;

    logic             CLK = 1'b0;
    logic             RES;
    logic             WE;
    logic [SW-1:0]    SEL;
    logic [1:0]       MODE;
    logic             IRQ_EN;
    logic [WIDTH-1:0] IN;
    logic             RE;
    logic [WIDTH-1:0] OUT;
    logic [NCH-1:0]   FLAG;
    logic             IRQ;

    int checks = 0;
    int errors = 0;

    itimer_nch #(
        .NCH  (NCH),
        .WIDTH(WIDTH),
        .SH1  (3),
        .SH2  (6),
        .SH3  (10)
    ) dut (
        .CLK   (CLK),
        .RES   (RES),
        .WE    (WE),
        .SEL   (SEL),
        .MODE  (MODE),
        .IRQ_EN(IRQ_EN),
        .IN    (IN),
        .RE    (RE),
        .OUT   (OUT),
        .FLAG  (FLAG),
        .IRQ   (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        WE = 1'b0;
        RE = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [SW-1:0] s, input logic [1:0] m,
                      input logic e, input logic [WIDTH-1:0] v);
        WE     = 1'b1;
        SEL    = s;
        MODE   = m;
        IRQ_EN = e;
        IN     = v;
        step();
    endtask

    initial begin
        logic [31:0] exp;
        RES = 1'b1; WE = 1'b0; RE = 1'b0; SEL = '0;
        MODE = 2'b00; IRQ_EN = 1'b0; IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out", 32'(OUT), 32'h0);
        chk("rst_flag", 32'(FLAG), 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        RES = 1'b0;
        #1;
        chk("rel_out", 32'(OUT), 32'h0);
        chk("rel_irq", 32'(IRQ), 32'h0);
        step();
        chk("rel1_flag", 32'(FLAG), 32'h7);
        chk("rel1_irq", 32'(IRQ), 32'h0);
        chk("rel1_out", 32'(OUT), 32'h1);

        // ch0 1T countdown from 5
        wr(2'd0, 2'b00, 1'b1, 8'h05);
        chk("w0_out", 32'(OUT), 32'h5);
        chk("w0_flag", 32'(FLAG[0]), 32'h0);
        chk("w0_irq", 32'(IRQ), 32'h0);
        for (int k = 4; k >= 0; k--) begin
            step();
            chk("c0_down", 32'(OUT), 32'(k));
        end
        step();
        chk("c0_uf_flag", 32'(FLAG[0]), 32'h1);
        chk("c0_uf_irq", 32'(IRQ), 32'h1);
        chk("c0_uf_out", 32'(OUT), 32'h1);
        step();
        chk("c0_up2", 32'(OUT), 32'h2);
        step();
        chk("c0_up3", 32'(OUT), 32'h3);

        // RE coinciding with underflow: set wins
        wr(2'd0, 2'b00, 1'b1, 8'h01);
        chk("re_w_out", 32'(OUT), 32'h1);
        chk("re_w_flag", 32'(FLAG[0]), 32'h0);
        step();
        chk("re_zero", 32'(OUT), 32'h0);
        RE = 1'b1;
        step();
        chk("re_same_flag", 32'(FLAG[0]), 32'h1);
        chk("re_same_irq", 32'(IRQ), 32'h1);
        RE = 1'b1;
        step();
        chk("re_next_flag", 32'(FLAG[0]), 32'h0);
        chk("re_next_irq", 32'(IRQ), 32'h0);

        // ch1 MODE=01, with a ch0 write in the middle
        wr(2'd1, 2'b01, 1'b0, 8'h02);
        chk("w1_out", 32'(OUT), 32'h2);
        for (int n = 1; n <= 25; n++) begin
            if (n == 10) begin
                WE = 1'b1; SEL = 2'd0; MODE = 2'b10;
                IRQ_EN = 1'b0; IN = 8'h33;
            end
            step();
            SEL = 2'd1;
            #1;
            if (n < 8)       exp = 32'h2;
            else if (n < 16) exp = 32'h1;
            else if (n < 24) exp = 32'h0;
            else             exp = 32'(n - 23);
            chk("c1_seq", 32'(OUT), exp);
            if (n == 23) chk("c1_flag_pre", 32'(FLAG[1]), 32'h0);
            if (n == 24) chk("c1_flag_uf", 32'(FLAG[1]), 32'h1);
        end
        SEL = 2'd0;
        #1;
        chk("c0_loaded", 32'(OUT), 32'h33);

        // out-of-range select: reads zero, write ignored
        WE = 1'b1; SEL = 2'd3; MODE = 2'b00; IRQ_EN = 1'b1; IN = 8'h77;
        #1;
        chk("sel3_out", 32'(OUT), 32'h0);
        step();
        SEL = 2'd0;
        #1;
        chk("sel3_c0", 32'(OUT), 32'h33);
        chk("sel3_flag", 32'(FLAG), 32'h6);
        chk("sel3_irq", 32'(IRQ), 32'h0);

        // ch2 MODE=11: first tick after 1024 clocks
        wr(2'd2, 2'b11, 1'b1, 8'h01);
        chk("w2_out", 32'(OUT), 32'h1);
        chk("w2_flag", 32'(FLAG[2]), 32'h0);
        for (int n = 1; n <= 2048; n++) begin
            step();
            if (n == 1023) chk("c2_1023", 32'(OUT), 32'h1);
            if (n == 1024) chk("c2_1024", 32'(OUT), 32'h0);
            if (n == 2047) begin
                chk("c2_2047", 32'(OUT), 32'h0);
                chk("c2_2047_flag", 32'(FLAG[2]), 32'h0);
            end
            if (n == 2048) begin
                chk("c2_2048", 32'(OUT), 32'h1);
                chk("c2_2048_flag", 32'(FLAG[2]), 32'h1);
                chk("c2_2048_irq", 32'(IRQ), 32'h1);
            end
        end

        // asynchronous reset mid-count
        @(posedge CLK);
        #3;
        RES = 1'b1;
        #1;
        chk("arst_out", 32'(OUT), 32'h0);
        chk("arst_flag", 32'(FLAG), 32'h0);
        chk("arst_irq", 32'(IRQ), 32'h0);
        @(posedge CLK);
        #1;
        RES = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
